// File: rtl/spike_class_decoder.sv
// ============================================================================
// spike_class_decoder : per-class spike counting followed by a sequential argmax
// Revision 1.0
// ============================================================================
`default_nettype none

module spike_class_decoder #(
  parameter int SIZE_SPIKE  = 10,
  parameter int NUM_CLASSES = 10,
  parameter int SIZE_COUNT  = 8,
  parameter int SIZE_CLASS  = $clog2(NUM_CLASSES)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic                  spike_valid,
  input  logic [SIZE_SPIKE-1:0] spike_addr,
  input  logic                  inference_done,
  output logic                  busy,
  output logic                  class_valid,
  output logic [SIZE_CLASS-1:0] class_out,
  output logic [SIZE_COUNT-1:0] class_count,
  output logic                  no_spike,
  output logic                  err_range
);

  localparam logic [1:0]            c_st_idle   = 2'd0;
  localparam logic [1:0]            c_st_accum  = 2'd1;
  localparam logic [1:0]            c_st_scan   = 2'd2;
  localparam logic [SIZE_CLASS-1:0] c_last_idx  = SIZE_CLASS'(NUM_CLASSES - 1);
  localparam logic [SIZE_SPIKE-1:0] c_num_addr  = SIZE_SPIKE'(NUM_CLASSES);
  localparam logic [SIZE_COUNT-1:0] c_count_max = '1;

  logic [1:0]            state_q, state_d;
  logic [SIZE_COUNT-1:0] cnt_q [NUM_CLASSES];
  logic [SIZE_COUNT-1:0] cnt_d [NUM_CLASSES];
  logic [SIZE_CLASS-1:0] idx_q, idx_d;
  logic [SIZE_CLASS-1:0] best_q, best_d;
  logic [SIZE_COUNT-1:0] best_count_q, best_count_d;
  logic [SIZE_CLASS-1:0] class_out_q, class_out_d;
  logic [SIZE_COUNT-1:0] class_count_q, class_count_d;
  logic                  no_spike_q, no_spike_d;
  logic                  err_range_q, err_range_d;
  logic                  class_valid_q, class_valid_d;
  logic                  w_accept;

  // A spike is accepted while accumulating, or alongside start (clear happens first).
  assign w_accept = start || (state_q == c_st_accum);

  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    idx_d         = idx_q;
    best_d        = best_q;
    best_count_d  = best_count_q;
    class_out_d   = class_out_q;
    class_count_d = class_count_q;
    no_spike_d    = no_spike_q;
    err_range_d   = err_range_q;
    class_valid_d = 1'b0;

    if (start) begin
      state_d = c_st_accum;
      for (int i = 0; i < NUM_CLASSES; i++) begin
        cnt_d[i] = '0;
      end
      err_range_d   = 1'b0;
      no_spike_d    = 1'b0;
      class_out_d   = '0;
      class_count_d = '0;
    end else begin
      case (state_q)
        c_st_accum: begin
          if (inference_done) begin
            state_d      = c_st_scan;
            idx_d        = '0;
            best_d       = '0;
            best_count_d = '0;
          end
        end
        c_st_scan: begin
          // Strict compare keeps the lowest index on ties.
          if (cnt_q[idx_q] > best_count_q) begin
            best_d       = idx_q;
            best_count_d = cnt_q[idx_q];
          end
          if (idx_q == c_last_idx) begin
            state_d       = c_st_idle;
            class_out_d   = best_d;
            class_count_d = best_count_d;
            no_spike_d    = (best_count_d == '0);
            class_valid_d = 1'b1;
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end
        default: ;
      endcase
    end

    if (spike_valid && w_accept) begin
      if (spike_addr >= c_num_addr) begin
        err_range_d = 1'b1;
      end else begin
        for (int i = 0; i < NUM_CLASSES; i++) begin
          if ((spike_addr == SIZE_SPIKE'(i)) && (cnt_d[i] != c_count_max)) begin
            cnt_d[i] = cnt_d[i] + 1'b1;
          end
        end
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= c_st_idle;
      for (int i = 0; i < NUM_CLASSES; i++) begin
        cnt_q[i] <= '0;
      end
      idx_q         <= '0;
      best_q        <= '0;
      best_count_q  <= '0;
      class_out_q   <= '0;
      class_count_q <= '0;
      no_spike_q    <= 1'b0;
      err_range_q   <= 1'b0;
      class_valid_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      idx_q         <= idx_d;
      best_q        <= best_d;
      best_count_q  <= best_count_d;
      class_out_q   <= class_out_d;
      class_count_q <= class_count_d;
      no_spike_q    <= no_spike_d;
      err_range_q   <= err_range_d;
      class_valid_q <= class_valid_d;
    end
  end

  assign busy        = (state_q != c_st_idle);
  assign class_valid = class_valid_q;
  assign class_out   = class_out_q;
  assign class_count = class_count_q;
  assign no_spike    = no_spike_q;
  assign err_range   = err_range_q;

endmodule

`default_nettype wire

// File: tb/tb_spike_class_decoder.sv
// ============================================================================
// tb_spike_class_decoder : scoreboard bench with a count-and-argmax reference model
// Revision 1.0
// ============================================================================
`default_nettype none

module tb_spike_class_decoder;

  logic       clk = 1'b0;
  logic       reset;
  logic       start;
  logic       spike_valid;
  logic [9:0] spike_addr;
  logic       inference_done;
  logic       busy;
  logic       class_valid;
  logic [3:0] class_out;
  logic [7:0] class_count;
  logic       no_spike;
  logic       err_range;

  spike_class_decoder dut (
    .clk            (clk),
    .reset          (reset),
    .start          (start),
    .spike_valid    (spike_valid),
    .spike_addr     (spike_addr),
    .inference_done (inference_done),
    .busy           (busy),
    .class_valid    (class_valid),
    .class_out      (class_out),
    .class_count    (class_count),
    .no_spike       (no_spike),
    .err_range      (err_range)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int cls;
    int cnt;
    bit nospk;
    bit err;
    int due;
  } exp_t;

  exp_t q[$];
  int   model_cnt [10];
  bit   model_err;
  bit   in_accum;
  int   checks   = 0;
  int   failures = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_clear();
    for (int i = 0; i < 10; i++) model_cnt[i] = 0;
    model_err = 1'b0;
  endtask

  // One stimulus cycle: inputs applied now, sampled at the next rising edge.
  task automatic drive(input bit st, input bit sv, input int addr, input bit done);
    exp_t e;
    int   mx;
    start          = st;
    spike_valid    = sv;
    spike_addr     = addr[9:0];
    inference_done = done;
    if (st) begin
      if (q.size() > 0 && q[$].due >= cyc + 1) void'(q.pop_back());
      model_clear();
    end
    if (sv && (st || in_accum)) begin
      if (addr < 10) model_cnt[addr] = (model_cnt[addr] >= 255) ? 255 : model_cnt[addr] + 1;
      else           model_err = 1'b1;
    end
    if (done && in_accum && !st) begin
      mx = 0;
      foreach (model_cnt[i]) if (model_cnt[i] > mx) mx = model_cnt[i];
      e.cls = 0;
      for (int i = 9; i >= 0; i--) if (model_cnt[i] == mx) e.cls = i;
      e.cnt   = mx;
      e.nospk = (mx == 0);
      e.err   = model_err;
      e.due   = cyc + 11;
      q.push_back(e);
      in_accum = 1'b0;
    end
    if (st) in_accum = 1'b1;
    @(posedge clk);
    #1;
    start          = 1'b0;
    spike_valid    = 1'b0;
    inference_done = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(1'b0, 1'b0, 0, 1'b0);
  endtask

  task automatic spikes(input int addr, input int n);
    for (int i = 0; i < n; i++) drive(1'b0, 1'b1, addr, 1'b0);
  endtask

  task automatic wait_result();
    int n;
    n = 0;
    while (q.size() != 0 && n < 40) begin
      @(posedge clk);
      #1;
      n++;
    end
    check("result_timeout_pending", q.size(), 0);
    q.delete();
  endtask

  always @(negedge clk) begin : monitor
    exp_t e;
    if (class_valid) begin
      if (q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_class_valid actual=1 expected=0 (t=%0t)", $time);
      end else begin
        e = q.pop_front();
        check("latency_cycle", cyc, e.due);
        check("class_out", class_out, e.cls);
        check("class_count", class_count, e.cnt);
        check("no_spike", no_spike, e.nospk);
        check("err_range_at_result", err_range, e.err);
        check("busy_at_result", busy, 0);
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog_timeout actual=running expected=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    reset          = 1'b1;
    start          = 1'b0;
    spike_valid    = 1'b0;
    spike_addr     = '0;
    inference_done = 1'b0;
    in_accum       = 1'b0;
    model_clear();
    repeat (3) @(posedge clk);
    #1;
    check("rst_busy", busy, 0);
    check("rst_class_valid", class_valid, 0);
    check("rst_class_out", class_out, 0);
    check("rst_class_count", class_count, 0);
    check("rst_no_spike", no_spike, 0);
    check("rst_err_range", err_range, 0);
    reset = 1'b0;
    idle(2);

    // Basic winner
    drive(1'b1, 1'b0, 0, 1'b0);
    check("busy_accum", busy, 1);
    spikes(3, 5);
    spikes(7, 2);
    drive(1'b0, 1'b0, 0, 1'b1);
    wait_result();

    // Tie resolves to lowest index
    drive(1'b1, 1'b0, 0, 1'b0);
    spikes(6, 4);
    spikes(2, 4);
    drive(1'b0, 1'b0, 0, 1'b1);
    wait_result();

    // No spikes at all
    drive(1'b1, 1'b0, 0, 1'b0);
    idle(3);
    drive(1'b0, 1'b0, 0, 1'b1);
    wait_result();

    // Saturation and out-of-range addresses
    drive(1'b1, 1'b0, 0, 1'b0);
    spikes(9, 300);
    spikes(10, 1);
    spikes(1023, 1);
    check("err_range_sticky", err_range, 1);
    drive(1'b0, 1'b0, 0, 1'b1);
    wait_result();
    drive(1'b1, 1'b0, 0, 1'b0);
    check("err_range_cleared", err_range, 0);
    check("class_count_cleared", class_count, 0);

    // Spikes coincident with start and inference_done; spikes during scan ignored
    drive(1'b1, 1'b1, 5, 1'b0);
    drive(1'b0, 1'b1, 5, 1'b1);
    spikes(1, 8);
    spikes(1000, 1);
    drive(1'b0, 1'b0, 0, 1'b1);
    wait_result();
    idle(2);
    check("held_class_out", class_out, 5);
    check("held_class_count", class_count, 2);

    // Abort mid-scan with start
    drive(1'b1, 1'b0, 0, 1'b0);
    spikes(4, 6);
    drive(1'b0, 1'b0, 0, 1'b1);
    idle(3);
    drive(1'b1, 1'b0, 0, 1'b0);
    check("abort_busy", busy, 1);
    check("abort_class_count", class_count, 0);
    idle(15);
    drive(1'b0, 1'b0, 0, 1'b1);
    wait_result();

    // Asynchronous reset mid-accumulation, between edges
    drive(1'b1, 1'b0, 0, 1'b0);
    spikes(8, 3);
    #3;
    reset = 1'b1;
    #1;
    check("async_busy", busy, 0);
    check("async_class_out", class_out, 0);
    check("async_class_count", class_count, 0);
    check("async_no_spike", no_spike, 0);
    in_accum = 1'b0;
    model_clear();
    q.delete();
    @(posedge clk);
    #1;
    reset = 1'b0;
    drive(1'b1, 1'b0, 0, 1'b0);
    spikes(8, 2);
    spikes(0, 1);
    drive(1'b0, 1'b0, 0, 1'b1);
    wait_result();

    // Randomized inferences
    for (int t = 0; t < 25; t++) begin
      int n;
      int addr;
      drive(1'b1, $urandom_range(0, 1) == 1, $urandom_range(0, 9), 1'b0);
      n = $urandom_range(0, 80);
      for (int k = 0; k < n; k++) begin
        if ($urandom_range(0, 15) == 0) addr = $urandom_range(10, 1023);
        else if ($urandom_range(0, 2) == 0) addr = t % 10;
        else addr = $urandom_range(0, 9);
        drive(1'b0, $urandom_range(0, 3) != 0, addr, 1'b0);
      end
      drive(1'b0, $urandom_range(0, 1) == 1, $urandom_range(0, 12), 1'b1);
      for (int k = 0; k < 6; k++)
        drive(1'b0, 1'b1, $urandom_range(0, 1023), $urandom_range(0, 3) == 0);
      wait_result();
      idle($urandom_range(0, 3));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
